// File: rtl/multicycle_seq.sv
// Multi-cycle instruction sequencer for the rv32 core: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, runs the memory handshakes and counts retired instructions.
module multicycle_seq #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             branch_taken,
  input  logic             halt,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             trap
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5,
    TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int          WAIT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit          TO_EN     = (TIMEOUT_CYC > 0);
  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT_CYC - 1);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    instret_q, instret_d;
  logic                br_q, br_d, jal_q, jal_d, jalr_q, jalr_d;
  logic                st_q, st_d, ldst_q, ldst_d, rw_q, rw_d;
  logic                legal, retire, timeout_hit, next_ok;
  logic                imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, rf_we_c, pc_we_c;
  logic [1:0]          pc_sel_c;

  always_comb begin
    unique case (opcode)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: legal = 1'b1;
      default:                                         legal = 1'b0;
    endcase
  end

  // The final no-ack cycle traps, but an ack on that same edge takes priority.
  assign timeout_hit = TO_EN && (32'(wait_q) == WAIT_LAST);
  assign next_ok     = 1'b1;

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    instret_d  = instret_q;
    br_d       = br_q;
    jal_d      = jal_q;
    jalr_d     = jalr_q;
    st_d       = st_q;
    ldst_d     = ldst_q;
    rw_d       = rw_q;
    retire     = 1'b0;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    ir_we_c    = 1'b0;
    rf_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    pc_sel_c   = 2'd0;

    case (state_q)
      FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          ir_we_c = 1'b1;
          state_d = DECODE;
        end else if (timeout_hit) begin
          state_d = TRAP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DECODE: begin
        br_d    = (opcode == OP_BRANCH);
        jal_d   = (opcode == OP_JAL);
        jalr_d  = (opcode == OP_JALR);
        st_d    = mem_write;
        ldst_d  = mem_read | mem_write;
        rw_d    = reg_write;
        state_d = legal ? EXEC : TRAP;
      end
      EXEC: begin
        if (br_q) begin
          pc_we_c  = 1'b1;
          pc_sel_c = branch_taken ? 2'd1 : 2'd0;
          retire   = 1'b1;
          state_d  = halt ? HALTED : FETCH;
        end else if (ldst_q) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = st_q;
        if (dmem_ack) begin
          if (st_q) begin
            pc_we_c = 1'b1;
            retire  = 1'b1;
            state_d = halt ? HALTED : FETCH;
          end else begin
            state_d = WB;
          end
        end else if (timeout_hit) begin
          state_d = TRAP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WB: begin
        rf_we_c  = rw_q;
        pc_we_c  = 1'b1;
        pc_sel_c = jal_q ? 2'd1 : (jalr_q ? 2'd2 : 2'd0);
        retire   = 1'b1;
        state_d  = halt ? HALTED : FETCH;
      end
      HALTED: begin
        if (!halt) state_d = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (retire && next_ok) instret_d = instret_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      br_q      <= 1'b0;
      jal_q     <= 1'b0;
      jalr_q    <= 1'b0;
      st_q      <= 1'b0;
      ldst_q    <= 1'b0;
      rw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      br_q      <= br_d;
      jal_q     <= jal_d;
      jalr_q    <= jalr_d;
      st_q      <= st_d;
      ldst_q    <= ldst_d;
      rw_q      <= rw_d;
    end
  end

  // Hold every strobe low while reset is asserted, even though FETCH is the reset state.
  assign imem_req = imem_req_c & ~rst;
  assign dmem_req = dmem_req_c & ~rst;
  assign dmem_we  = dmem_we_c & ~rst;
  assign ir_we    = ir_we_c & ~rst;
  assign rf_we    = rf_we_c & ~rst;
  assign pc_we    = pc_we_c & ~rst;
  assign pc_sel   = rst ? 2'd0 : pc_sel_c;
  assign state    = state_q;
  assign instret  = instret_q;
  assign trap     = (state_q == TRAP);

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: directed scenarios plus randomized instruction
// streams checked cycle by cycle against a phase-level model of the instruction timeline.
module tb_multicycle_seq;

  localparam int TO = 255;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic       reg_write, mem_read, mem_write, branch_taken, halt;
  logic       imem_ack, dmem_ack;
  logic       imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we;
  logic [1:0] pc_sel;
  logic [2:0] state;
  logic [3:0] instret;
  logic       trap;

  int         n_chk;
  int         n_err;
  logic [3:0] exp_cnt;
  bit         trapped;

  multicycle_seq #(.CNT_W(4), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch_taken(branch_taken), .halt(halt),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .state(state), .instret(instret), .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  localparam logic [6:0] ADD = 7'b0110011, ADDI = 7'b0010011, LW = 7'b0000011,
                         SW = 7'b0100011, BEQ = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

  wire logic [11:0] obs = {imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, pc_sel, state, trap};

  function automatic logic [11:0] ex(input logic [2:0] st, input logic imr, dmr, dwe, irw,
                                     rfw, pcw, input logic [1:0] ps);
    return {imr, dmr, dwe, irw, rfw, pcw, ps, st, st == 3'd6};
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {ADD, ADDI, LW, SW, BEQ, JAL, JALR, LUI, AUIPC};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // Called just after a rising edge with inputs already driven for this cycle.
  task automatic step_chk(input string tag, input logic [11:0] want);
    @(negedge clk);
    check(tag, {20'd0, obs}, {20'd0, want});
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    imem_ack = 1'($urandom);
    dmem_ack = 1'($urandom);
    halt     = 1'($urandom);
  endtask

  task automatic retired();
    exp_cnt = exp_cnt + 4'd1;
    check("instret", {28'd0, instret}, {28'd0, exp_cnt});
  endtask

  task automatic trap_check(input string tag);
    trapped = 1'b1;
    for (int i = 0; i < 3; i++) begin
      noise();
      step_chk(tag, ex(3'd6, 0, 0, 0, 0, 0, 0, 2'd0));
    end
    check("trap_instret", {28'd0, instret}, {28'd0, exp_cnt});
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_out", {20'd0, obs}, {20'd0, ex(3'd0, 0, 0, 0, 0, 0, 0, 2'd0)});
    check("rst_instret", {28'd0, instret}, 32'd0);
    noise();
    @(posedge clk);
    #1;
    check("rst_hold", {20'd0, obs}, {20'd0, ex(3'd0, 0, 0, 0, 0, 0, 0, 2'd0)});
    rst = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    halt = 1'b0;
    exp_cnt = 4'd0;
    trapped = 1'b0;
  endtask

  // Timeline of one instruction: FETCH waits, DECODE, EXEC, optional MEM waits, optional WB.
  task automatic run_instr(input logic [6:0] opc, input bit rw, mr, mw, bt,
                           input int di, dd, input bit hlt, input int hold);
    logic [1:0] wb_sel;
    wb_sel = (opc == JAL) ? 2'd1 : ((opc == JALR) ? 2'd2 : 2'd0);
    for (int i = 0; i < di && i < TO; i++) begin
      noise();
      imem_ack = 1'b0;
      opcode = 7'($urandom);
      step_chk("fetch_wait", ex(3'd0, 1, 0, 0, 0, 0, 0, 2'd0));
    end
    if (di >= TO) begin
      trap_check("imem_timeout");
      return;
    end
    noise();
    imem_ack = 1'b1;
    step_chk("fetch_ack", ex(3'd0, 1, 0, 0, 1, 0, 0, 2'd0));
    noise();
    opcode = opc; reg_write = rw; mem_read = mr; mem_write = mw;
    step_chk("decode", ex(3'd1, 0, 0, 0, 0, 0, 0, 2'd0));
    if (!is_legal(opc)) begin
      trap_check("illegal");
      return;
    end
    noise();
    halt = hlt;
    branch_taken = bt;
    if (opc == BEQ) begin
      step_chk("exec_br", ex(3'd2, 0, 0, 0, 0, 0, 1, bt ? 2'd1 : 2'd0));
      retired();
    end else begin
      step_chk("exec", ex(3'd2, 0, 0, 0, 0, 0, 0, 2'd0));
      if (mr || mw) begin
        for (int i = 0; i < dd && i < TO; i++) begin
          noise();
          halt = hlt;
          dmem_ack = 1'b0;
          step_chk("mem_wait", ex(3'd3, 0, 1, mw, 0, 0, 0, 2'd0));
        end
        if (dd >= TO) begin
          trap_check("dmem_timeout");
          return;
        end
        noise();
        halt = hlt;
        dmem_ack = 1'b1;
        if (mw) begin
          step_chk("mem_store", ex(3'd3, 0, 1, 1, 0, 0, 1, 2'd0));
          retired();
        end else begin
          step_chk("mem_load", ex(3'd3, 0, 1, 0, 0, 0, 0, 2'd0));
        end
      end
      if (!mw) begin
        noise();
        halt = hlt;
        step_chk("wb", ex(3'd4, 0, 0, 0, 0, rw, 1, wb_sel));
        retired();
      end
    end
    if (hlt) begin
      for (int i = 0; i < hold; i++) begin
        noise();
        halt = 1'b1;
        step_chk("halted", ex(3'd5, 0, 0, 0, 0, 0, 0, 2'd0));
      end
      noise();
      halt = 1'b0;
      step_chk("halted_exit", ex(3'd5, 0, 0, 0, 0, 0, 0, 2'd0));
    end
  endtask

  task automatic rand_instr();
    int k;
    logic [6:0] op;
    bit rw, mr, mw, bt, hl;
    int di, dd;
    k  = $urandom_range(0, 8);
    mr = 1'b0; mw = 1'b0; rw = 1'b1;
    case (k)
      0: begin op = ADD; rw = 1'($urandom); end
      1: op = ADDI;
      2: begin op = LW; mr = 1'b1; end
      3: begin op = SW; mw = 1'b1; rw = 1'b0; end
      4: begin op = BEQ; rw = 1'b0; end
      5: op = JAL;
      6: op = JALR;
      7: op = LUI;
      default: op = AUIPC;
    endcase
    if ($urandom_range(0, 19) == 0) begin
      op = 7'($urandom);
      while (is_legal(op)) op = 7'($urandom);
    end
    bt = 1'($urandom);
    hl = ($urandom_range(0, 5) == 0);
    di = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
    dd = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
    run_instr(op, rw, mr, mw, bt, di, dd, hl, $urandom_range(0, 3));
  endtask

  initial begin
    n_chk = 0; n_err = 0; exp_cnt = 4'd0; trapped = 1'b0;
    rst = 1'b1;
    opcode = 7'd0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    branch_taken = 1'b0; halt = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    run_instr(ADD,   1, 0, 0, 0, 0, 0, 0, 0);
    run_instr(LW,    1, 1, 0, 0, 3, 2, 0, 0);
    run_instr(BEQ,   0, 0, 0, 1, 0, 0, 0, 0);
    run_instr(BEQ,   0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(JALR,  1, 0, 0, 0, 0, 0, 0, 0);
    run_instr(SW,    0, 0, 1, 0, 0, 1, 0, 0);
    run_instr(ADDI,  1, 0, 0, 0, 0, 0, 1, 2);
    run_instr(JAL,   1, 0, 0, 0, 1, 0, 0, 0);
    run_instr(SW,    0, 0, 1, 0, 0, 0, 1, 1);
    run_instr(BEQ,   0, 0, 0, 1, 0, 0, 1, 0);
    run_instr(LUI,   1, 0, 0, 0, 0, 0, 0, 0);
    run_instr(AUIPC, 1, 0, 0, 0, 0, 0, 0, 0);
    run_instr(LW,    1, 1, 0, 0, TO - 1, TO - 1, 0, 0);

    run_instr(7'b1111111, 1, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    run_instr(ADD, 1, 0, 0, 0, 0, 0, 0, 0);
    run_instr(SW,  0, 0, 1, 0, 0, TO, 0, 0);
    do_reset();
    run_instr(ADD, 1, 0, 0, 0, TO, 0, 0, 0);
    do_reset();

    // Reset asserted in the middle of a load's memory wait.
    run_instr(ADD, 1, 0, 0, 0, 0, 0, 0, 0);
    imem_ack = 1'b1;
    step_chk("mr_fetch", ex(3'd0, 1, 0, 0, 1, 0, 0, 2'd0));
    imem_ack = 1'b0; opcode = LW; reg_write = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    step_chk("mr_decode", ex(3'd1, 0, 0, 0, 0, 0, 0, 2'd0));
    step_chk("mr_exec", ex(3'd2, 0, 0, 0, 0, 0, 0, 2'd0));
    dmem_ack = 1'b0;
    step_chk("mr_mem", ex(3'd3, 0, 1, 0, 0, 0, 0, 2'd0));
    do_reset();
    step_chk("post_rst_fetch", ex(3'd0, 1, 0, 0, 0, 0, 0, 2'd0));

    for (int i = 0; i < 17; i++) run_instr(ADD, 1, 0, 0, 0, 0, 0, 0, 0);
    check("wrap", {28'd0, instret}, 32'd1);

    for (int i = 0; i < 120; i++) begin
      rand_instr();
      if (trapped) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
